uart_rx_nibble: RTL and testbench



---
 rtl/uart_rx_nibble.sv | 152 +++++++++++++++
 tb/tb_uart_rx_nibble.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_nibble.sv
// UART 8N1 receiver front end. Deserialises frames from the asynchronous rx
// pin, holds one byte and presents it to the host a nibble at a time, low
// nibble first. Sticky flags report framing errors and dropped bytes.
//
// state | meaning
// IDLE  | line idle, waiting for a start-bit falling edge
// START | timing to mid start bit to confirm it (glitch reject)
// DATA  | sampling 8 data bits at mid-bit, LSB first
// STOP  | sampling the stop bit, then straight back to IDLE
module uart_rx_nibble #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_nibble,
  input  logic       clr_err,
  output logic [3:0] data_out,
  output logic       data_valid,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_cnt, bit_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          sync1, rxs;
  logic          stop_ok, stop_bad;
  logic [7:0]    hold;
  logic          nib_sel;

  // Two-flop synchronizer for the asynchronous rx pin; resets to line-idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
    end
  end

  // Receive FSM and timing counters register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_cnt <= bit_nx;
      shreg   <= shreg_nx;
    end
  end

  // Next-state, counter and sampling decisions.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bit_nx   = bit_cnt;
    shreg_nx = shreg;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    case (state)
      IDLE: begin
        bit_nx = '0;
        if (!rxs) begin
          state_nx = START;
          cnt_nx   = '0;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_nx   = '0;
          state_nx = rxs ? IDLE : DATA;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_nx   = '0;
          shreg_nx = {rxs, shreg[7:1]};
          bit_nx   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nx = STOP;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_nx   = '0;
          state_nx = IDLE;
          stop_ok  = rxs;
          stop_bad = !rxs;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Holding register, nibble unload and sticky flags. A completing byte may
  // load in the same cycle as the read that empties the register.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold       <= '0;
      data_valid <= 1'b0;
      nib_sel    <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (clr_err) begin
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end
      if (rd_nibble && data_valid) begin
        if (nib_sel) begin
          data_valid <= 1'b0;
          nib_sel    <= 1'b0;
        end else begin
          nib_sel <= 1'b1;
        end
      end
      if (stop_ok) begin
        if (!data_valid || (rd_nibble && nib_sel)) begin
          hold       <= shreg;
          data_valid <= 1'b1;
          nib_sel    <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end
      if (stop_bad) frame_err <= 1'b1;
    end
  end

  assign busy     = (state != IDLE);
  assign data_out = !data_valid ? 4'h0 : (nib_sel ? hold[7:4] : hold[3:0]);

endmodule

// File: tb/tb_uart_rx_nibble.sv
// Self-checking bench for uart_rx_nibble at 8 clocks per bit: table of
// single frames plus hand-written sequences for overrun, read/complete
// collision, start glitch and mid-frame reset.
module tb_uart_rx_nibble;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       reset, rx, rd_nibble, clr_err;
  logic [3:0] data_out;
  logic       data_valid, busy, frame_err, overrun;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
  } vec_t;
  vec_t vecs[6];

  uart_rx_nibble #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rd_nibble(rd_nibble),
    .clr_err(clr_err), .data_out(data_out), .data_valid(data_valid),
    .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drives a full 10-bit frame, one cycle per loop pass. rd_nibble pulses in
  // cycle rd_at (its edge is the stop-bit sample when rd_at = 78). A reset
  // in cycle rst_at aborts the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int rd_at, input int rst_at);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      rx        = bits[c / CPB];
      rd_nibble = (c == rd_at);
      if (c == rst_at) begin
        reset = 1'b1;
        rx    = 1'b1;
        tick();
        reset = 1'b0;
        rd_nibble = 1'b0;
        return;
      end
      tick();
    end
    rd_nibble = 1'b0;
  endtask

  task automatic pulse_rd();
    rd_nibble = 1'b1;
    tick();
    rd_nibble = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  // Pops the next expected byte and unloads it from the DUT.
  task automatic read_byte(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_valid"}, data_valid, 1);
    check({tag, "_lo"}, data_out, e[3:0]);
    pulse_rd();
    check({tag, "_hi"}, data_out, e[7:4]);
    pulse_rd();
    check({tag, "_empty_valid"}, data_valid, 0);
    check({tag, "_empty_out"}, data_out, 0);
  endtask

  initial begin
    logic saw_busy;
    vecs[0] = '{8'hA5, 1'b1};
    vecs[1] = '{8'h3C, 1'b0};
    vecs[2] = '{8'hFF, 1'b1};
    vecs[3] = '{8'h00, 1'b1};
    vecs[4] = '{8'h81, 1'b0};
    vecs[5] = '{8'h5A, 1'b1};

    reset = 1'b1; rx = 1'b1; rd_nibble = 1'b0; clr_err = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_out", data_out, 0);
    check("rst_valid", data_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);

    // Single frames, good and bad stop bits.
    foreach (vecs[i]) begin
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop, -1, -1);
      idle(12);
      check($sformatf("v%0d_busy", i), busy, 0);
      check($sformatf("v%0d_ferr", i), frame_err, !vecs[i].stop);
      check($sformatf("v%0d_ovr", i), overrun, 0);
      if (vecs[i].stop) begin
        read_byte($sformatf("v%0d", i));
      end else begin
        check($sformatf("v%0d_valid", i), data_valid, 0);
        check($sformatf("v%0d_out", i), data_out, 0);
        pulse_clr();
        check($sformatf("v%0d_ferr_clr", i), frame_err, 0);
      end
    end

    // Start-bit glitch: busy pulses, nothing is received.
    saw_busy = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); saw_busy |= busy; end
    rx = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(); saw_busy |= busy; end
    check("glitch_saw_busy", saw_busy, 1);
    check("glitch_busy_end", busy, 0);
    idle(20);
    check("glitch_valid", data_valid, 0);
    check("glitch_ferr", frame_err, 0);
    check("glitch_ovr", overrun, 0);

    // Back-to-back frames with no reads: second byte dropped.
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, -1, -1);
    idle(12);
    check("ovr_flag", overrun, 1);
    check("ovr_ferr", frame_err, 0);
    read_byte("ovr");
    pulse_clr();
    check("ovr_clr", overrun, 0);

    // Final read coincides with the next stop-bit sample: byte loads, no overrun.
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, -1, -1);
    idle(4);
    check("col_lo", data_out, 4'h1);
    pulse_rd();
    check("col_hi", data_out, 4'h1);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, 10 * CPB - 2, -1);
    check("col_out", data_out, 4'h2);
    check("col_ovr", overrun, 0);
    idle(12);
    read_byte("col");

    // Reset during the 4th data bit with a byte held.
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b1, -1, -1);
    idle(4);
    check("mr_pre_valid", data_valid, 1);
    send_frame(8'hC3, 1'b1, -1, 4 * CPB + 3);
    exp_q.delete();
    check("mr_busy", busy, 0);
    check("mr_valid", data_valid, 0);
    check("mr_out", data_out, 0);
    check("mr_ferr", frame_err, 0);
    check("mr_ovr", overrun, 0);
    idle(4);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, -1, -1);
    idle(12);
    read_byte("mr_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
